// File: rtl/usb_ep_pkg.sv
// Endpoint-level types and limits for the USB protocol engine.
package usb_ep_pkg;

    localparam int unsigned IN_CTRL_MAX_EPS = 16;

    typedef enum logic [2:0] {
        InIdle,
        InDecide,
        InSendHs,
        InSendData,
        InWaitTxDone,
        InWaitHs
    } InTransState_t;

endpackage

// File: rtl/usb_packet_pkg.sv
// USB packet identifier values shared by the protocol engine blocks.
package usb_packet_pkg;

    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    function automatic logic [3:0] data_pid(input logic toggle);
        return toggle ? PID_DATA1 : PID_DATA0;
    endfunction

endpackage

// File: rtl/usb_turnaround_timer.sv
// Counts cycles while enabled; expired_o holds once TIMEOUT_CYCLES is reached until cleared.
module usb_turnaround_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 24
) (
    input  logic clk12_i,
    input  logic rstn_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT_CYCLES);

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk12_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (enable_i && (cnt_q != Limit)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired_o = (cnt_q == Limit);

endmodule

// File: rtl/usb_in_trans_ctrl.sv
// USB IN transaction sequencer: STALL/NAK/DATAx response, FIFO commit/rewind, data toggles.
// Define USB_IN_ZLP_EN to send a zero-length packet after an ACKed max-size packet.
module usb_in_trans_ctrl
    import usb_ep_pkg::*;
    import usb_packet_pkg::*;
#(
    parameter int unsigned ENDPOINTS       = 4,
    parameter int unsigned MAX_PACKET_SIZE = 64,
    parameter int unsigned TIMEOUT_CYCLES  = 24
) (
    input  logic                   clk12_i,
    input  logic                   rstn_i,
    input  logic                   inTokenValid_i,
    input  logic [3:0]             inTokenEp_i,
    input  logic [ENDPOINTS-1:0]   epHalted_i,
    input  logic [ENDPOINTS-1:0]   resetDataToggle_i,
    input  logic [ENDPOINTS-1:0]   EP_IN_dataAvailable_i,
    input  logic [8*ENDPOINTS-1:0] EP_IN_data_i,
    output logic [ENDPOINTS-1:0]   EP_IN_popData_o,
    output logic [ENDPOINTS-1:0]   EP_IN_popTransDone_o,
    output logic [ENDPOINTS-1:0]   EP_IN_popTransSuccess_o,
    output logic                   txStart_o,
    output logic [3:0]             txPid_o,
    output logic                   txDataValid_o,
    output logic [7:0]             txData_o,
    output logic                   txIsLast_o,
    input  logic                   txDataReady_i,
    input  logic                   txDone_i,
    input  logic                   rxHandshakeValid_i,
    input  logic                   rxHandshakeAck_i,
    output logic                   busy_o
);

    localparam int unsigned EpW = (ENDPOINTS > 1) ? $clog2(ENDPOINTS) : 1;
    localparam int unsigned NumEpsClamped =
        (ENDPOINTS > IN_CTRL_MAX_EPS) ? IN_CTRL_MAX_EPS : ENDPOINTS;
    localparam logic [4:0]  NumEps = 5'(NumEpsClamped);
    localparam logic [10:0] Mps    = 11'(MAX_PACKET_SIZE);
    localparam logic [10:0] MpsM1  = 11'(MAX_PACKET_SIZE - 1);

    InTransState_t        state_q;
    InTransState_t        dec_next;
    logic [EpW-1:0]       ep_q;
    logic                 is_data_q;
    logic [3:0]           pid_q;
    logic [10:0]          cnt_q;
    logic [ENDPOINTS-1:0] toggle_q, toggle_d;
    logic [ENDPOINTS-1:0] done_q, succ_q;
    logic [ENDPOINTS-1:0] ep_oh;
    logic [7:0]           data_sel;
    logic                 avail_sel, halt_sel, tog_sel, zlp_sel;
    logic                 in_data, xfer, hs_evt, ack_evt, expired;
    logic [3:0]           dec_pid;
    logic                 dec_data;

    // Per-endpoint selection through constant indices keeps every slice in range.
    always_comb begin
        ep_oh    = '0;
        data_sel = 8'h00;
        for (int n = 0; n < ENDPOINTS; n++) begin
            ep_oh[n] = (ep_q == EpW'(n));
            if (ep_oh[n]) begin
                data_sel = EP_IN_data_i[8*n +: 8];
            end
        end
    end

    assign avail_sel = |(EP_IN_dataAvailable_i & ep_oh);
    assign halt_sel  = |(epHalted_i & ep_oh);
    assign tog_sel   = |(toggle_q & ep_oh);

    assign in_data = (state_q == InSendData);
    assign xfer    = in_data && avail_sel && txDataReady_i;
    assign hs_evt  = (state_q == InWaitHs) && rxHandshakeValid_i;
    assign ack_evt = hs_evt && rxHandshakeAck_i;

`ifdef USB_IN_ZLP_EN
    logic [ENDPOINTS-1:0] zlp_q, zlp_d;

    // Flag follows the length of the most recently ACKed packet on that endpoint.
    assign zlp_d = ack_evt ? ((zlp_q & ~ep_oh) | (ep_oh & {ENDPOINTS{cnt_q == Mps}})) : zlp_q;
    assign zlp_sel = |(zlp_q & ep_oh);

    always_ff @(posedge clk12_i or negedge rstn_i) begin
        if (!rstn_i) begin
            zlp_q <= '0;
        end else begin
            zlp_q <= zlp_d;
        end
    end
`else
    assign zlp_sel = 1'b0;
`endif

    always_comb begin
        dec_pid  = data_pid(tog_sel);
        dec_data = 1'b1;
        dec_next = InSendData;
        if (halt_sel) begin
            dec_pid  = PID_STALL;
            dec_data = 1'b0;
            dec_next = InSendHs;
        end else if (!avail_sel) begin
            if (zlp_sel) begin
                dec_next = InWaitTxDone;
            end else begin
                dec_pid  = PID_NAK;
                dec_data = 1'b0;
                dec_next = InSendHs;
            end
        end
    end

    // Clear request wins over a coincident ACK flip.
    assign toggle_d = (ack_evt ? (toggle_q ^ ep_oh) : toggle_q) & ~resetDataToggle_i;

    always_ff @(posedge clk12_i or negedge rstn_i) begin
        if (!rstn_i) begin
            toggle_q <= '0;
        end else begin
            toggle_q <= toggle_d;
        end
    end

    always_ff @(posedge clk12_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= InIdle;
            ep_q      <= '0;
            is_data_q <= 1'b0;
            pid_q     <= 4'h0;
            cnt_q     <= '0;
            done_q    <= '0;
            succ_q    <= '0;
        end else begin
            done_q <= '0;
            succ_q <= '0;
            case (state_q)
                InIdle: begin
                    if (inTokenValid_i && ({1'b0, inTokenEp_i} < NumEps)) begin
                        ep_q    <= inTokenEp_i[EpW-1:0];
                        state_q <= InDecide;
                    end
                end
                InDecide: begin
                    cnt_q     <= '0;
                    pid_q     <= dec_pid;
                    is_data_q <= dec_data;
                    state_q   <= dec_next;
                end
                InSendHs: begin
                    state_q <= InWaitTxDone;
                end
                InSendData: begin
                    if (xfer) begin
                        cnt_q <= cnt_q + 11'd1;
                    end
                    if ((xfer && (cnt_q == MpsM1)) || !avail_sel) begin
                        state_q <= InWaitTxDone;
                    end
                end
                InWaitTxDone: begin
                    if (txDone_i) begin
                        state_q <= is_data_q ? InWaitHs : InIdle;
                    end
                end
                InWaitHs: begin
                    if (hs_evt) begin
                        done_q  <= ep_oh;
                        succ_q  <= rxHandshakeAck_i ? ep_oh : '0;
                        state_q <= InIdle;
                    end else if (expired) begin
                        done_q  <= ep_oh;
                        state_q <= InIdle;
                    end
                end
                default: state_q <= InIdle;
            endcase
        end
    end

    usb_turnaround_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk12_i   (clk12_i),
        .rstn_i    (rstn_i),
        .clear_i   (state_q == InWaitTxDone),
        .enable_i  (state_q == InWaitHs),
        .expired_o (expired)
    );

    assign busy_o                  = (state_q != InIdle);
    assign txStart_o               = (state_q == InDecide);
    assign txPid_o                 = (state_q == InDecide) ? dec_pid : pid_q;
    assign txDataValid_o           = in_data && avail_sel;
    assign txData_o                = in_data ? data_sel : 8'h00;
    // End of data is also signalled when availability falls, as a valid-low cycle.
    assign txIsLast_o              = in_data && (!avail_sel || (cnt_q == MpsM1));
    assign EP_IN_popData_o         = xfer ? ep_oh : '0;
    assign EP_IN_popTransDone_o    = done_q;
    assign EP_IN_popTransSuccess_o = succ_q;

endmodule

// File: tb/tb_usb_in_trans_ctrl.sv
// Directed bench for usb_in_trans_ctrl with a rewindable FIFO model per endpoint.
module tb_usb_in_trans_ctrl;

    localparam logic [3:0] P_DATA0 = 4'b0011;
    localparam logic [3:0] P_DATA1 = 4'b1011;
    localparam logic [3:0] P_NAK   = 4'b1010;
    localparam logic [3:0] P_STALL = 4'b1110;

    logic        clk12_i = 1'b0;
    logic        rstn_i;
    logic        inTokenValid_i;
    logic [3:0]  inTokenEp_i;
    logic [3:0]  epHalted_i;
    logic [3:0]  resetDataToggle_i;
    logic [3:0]  EP_IN_dataAvailable_i;
    logic [31:0] EP_IN_data_i;
    logic [3:0]  EP_IN_popData_o;
    logic [3:0]  EP_IN_popTransDone_o;
    logic [3:0]  EP_IN_popTransSuccess_o;
    logic        txStart_o;
    logic [3:0]  txPid_o;
    logic        txDataValid_o;
    logic [7:0]  txData_o;
    logic        txIsLast_o;
    logic        txDataReady_i;
    logic        txDone_i;
    logic        rxHandshakeValid_i;
    logic        rxHandshakeAck_i;
    logic        busy_o;

    int errors = 0;
    int checks = 0;

    usb_in_trans_ctrl dut (
        .clk12_i                 (clk12_i),
        .rstn_i                  (rstn_i),
        .inTokenValid_i          (inTokenValid_i),
        .inTokenEp_i             (inTokenEp_i),
        .epHalted_i              (epHalted_i),
        .resetDataToggle_i       (resetDataToggle_i),
        .EP_IN_dataAvailable_i   (EP_IN_dataAvailable_i),
        .EP_IN_data_i            (EP_IN_data_i),
        .EP_IN_popData_o         (EP_IN_popData_o),
        .EP_IN_popTransDone_o    (EP_IN_popTransDone_o),
        .EP_IN_popTransSuccess_o (EP_IN_popTransSuccess_o),
        .txStart_o               (txStart_o),
        .txPid_o                 (txPid_o),
        .txDataValid_o           (txDataValid_o),
        .txData_o                (txData_o),
        .txIsLast_o              (txIsLast_o),
        .txDataReady_i           (txDataReady_i),
        .txDone_i                (txDone_i),
        .rxHandshakeValid_i      (rxHandshakeValid_i),
        .rxHandshakeAck_i        (rxHandshakeAck_i),
        .busy_o                  (busy_o)
    );

    always #5 clk12_i = ~clk12_i;

    // FIFO model: committed base, read pointer, write pointer per endpoint.
    logic [7:0] mem  [4][256];
    logic [7:0] rd   [4];
    logic [7:0] wr   [4];
    logic [7:0] base [4];

    always_comb begin
        for (int n = 0; n < 4; n++) begin
            EP_IN_dataAvailable_i[n] = (rd[n] != wr[n]);
            EP_IN_data_i[8*n +: 8]   = mem[n][rd[n]];
        end
    end

    always @(posedge clk12_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int n = 0; n < 4; n++) begin
                rd[n]   <= 8'd0;
                base[n] <= 8'd0;
            end
        end else begin
            for (int n = 0; n < 4; n++) begin
                if (EP_IN_popData_o[n]) rd[n] <= rd[n] + 8'd1;
                if (EP_IN_popTransDone_o[n]) begin
                    if (EP_IN_popTransSuccess_o[n]) base[n] <= rd[n];
                    else rd[n] <= base[n];
                end
            end
        end
    end

    // Transmitter-side monitor, sampled on the inactive edge.
    int         n_start = 0, ncap = 0, npop = 0, ndone = 0, pkt_base = 0, last_at = 0;
    logic       last_seen = 1'b0;
    logic [3:0] last_pid = 4'h0, done_v = 4'h0, succ_v = 4'h0;
    logic [7:0] cap [512];

    always @(negedge clk12_i) begin
        if (txStart_o) begin
            n_start   <= n_start + 1;
            last_pid  <= txPid_o;
            pkt_base  <= ncap;
            last_seen <= 1'b0;
        end
        if (txDataValid_o && txDataReady_i) begin
            cap[ncap] <= txData_o;
            ncap      <= ncap + 1;
        end
        if (txIsLast_o && !last_seen) begin
            last_seen <= 1'b1;
            last_at   <= ncap + ((txDataValid_o && txDataReady_i) ? 1 : 0) - pkt_base;
        end
        if (|EP_IN_popData_o) npop <= npop + 1;
        if (|EP_IN_popTransDone_o) begin
            ndone  <= ndone + 1;
            done_v <= EP_IN_popTransDone_o;
            succ_v <= EP_IN_popTransSuccess_o;
        end
    end

    task automatic tick();
        @(posedge clk12_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int ep, input int cnt, input logic [7:0] first);
        for (int i = 0; i < cnt; i++) begin
            mem[ep][wr[ep]] = first + 8'(i);
            wr[ep] = wr[ep] + 8'd1;
        end
    endtask

    // hs: 0 = ACK, 2 = host silent, 3 = ACK with toggle clear in the same cycle.
    task automatic do_in(input logic [3:0] ep, input logic [3:0] exp_pid, input int exp_n,
                         input logic [7:0] first, input int hs, input string tag);
        int s_start, s_cap, s_pop, s_done, k;
        logic is_data;
        logic [3:0] oh;
        oh      = 4'(1 << ep);
        is_data = (exp_pid == P_DATA0) || (exp_pid == P_DATA1);
        s_start = n_start;
        s_cap   = ncap;
        s_pop   = npop;
        s_done  = ndone;
        inTokenValid_i = 1'b1;
        inTokenEp_i    = ep;
        tick();
        inTokenValid_i = 1'b0;
        tick();
        check({tag, "_start"}, n_start - s_start, 1);
        check({tag, "_pid"}, last_pid, exp_pid);
        if (exp_n > 0) begin
            k = 0;
            while (!last_seen && k < 200) begin
                tick();
                k++;
            end
            check({tag, "_last_seen"}, last_seen, 1);
            check({tag, "_nbytes"}, ncap - s_cap, exp_n);
            check({tag, "_last_at"}, last_at, exp_n);
            check({tag, "_npops"}, npop - s_pop, exp_n);
            check({tag, "_byte_first"}, cap[s_cap], first);
            check({tag, "_byte_last"}, cap[s_cap + exp_n - 1], first + 8'(exp_n - 1));
        end
        if (!is_data) begin
            inTokenValid_i = 1'b1;
            inTokenEp_i    = 4'd1;
            tick();
            inTokenValid_i = 1'b0;
        end
        tick();
        txDone_i = 1'b1;
        tick();
        txDone_i = 1'b0;
        if (is_data) begin
            if (hs == 2) begin
                k = 0;
                while (ndone == s_done && k < 60) begin
                    tick();
                    k++;
                end
                check({tag, "_timeout_window"}, (k >= 24 && k <= 30), 1);
                check({tag, "_done"}, done_v, oh);
                check({tag, "_succ"}, succ_v, 4'h0);
            end else begin
                tick();
                rxHandshakeValid_i = 1'b1;
                rxHandshakeAck_i   = 1'b1;
                if (hs == 3) resetDataToggle_i = oh;
                tick();
                rxHandshakeValid_i = 1'b0;
                rxHandshakeAck_i   = 1'b0;
                resetDataToggle_i  = 4'h0;
                tick();
                tick();
                check({tag, "_ndone"}, ndone - s_done, 1);
                check({tag, "_done"}, done_v, oh);
                check({tag, "_succ"}, succ_v, oh);
            end
        end else begin
            repeat (3) tick();
            check({tag, "_no_done"}, ndone - s_done, 0);
            check({tag, "_single_start"}, n_start - s_start, 1);
        end
        if (exp_n == 0) check({tag, "_no_pop"}, npop - s_pop, 0);
        check({tag, "_idle"}, busy_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        rstn_i             = 1'b0;
        inTokenValid_i     = 1'b0;
        inTokenEp_i        = 4'h0;
        epHalted_i         = 4'h0;
        resetDataToggle_i  = 4'h0;
        txDataReady_i      = 1'b1;
        txDone_i           = 1'b0;
        rxHandshakeValid_i = 1'b0;
        rxHandshakeAck_i   = 1'b0;
        for (int n = 0; n < 4; n++) wr[n] = 8'd0;
        repeat (3) tick();
        rstn_i = 1'b1;
        tick();

        check("rst_busy", busy_o, 0);
        check("rst_txStart", txStart_o, 0);
        check("rst_txPid", txPid_o, 0);
        check("rst_txValid", txDataValid_o, 0);
        check("rst_txIsLast", txIsLast_o, 0);
        check("rst_pop", EP_IN_popData_o, 0);
        check("rst_done", EP_IN_popTransDone_o, 0);
        check("rst_succ", EP_IN_popTransSuccess_o, 0);

        load(1, 3, 8'hA0);
        do_in(4'd1, P_DATA0, 3, 8'hA0, 2, "ep1_timeout");
        do_in(4'd1, P_DATA0, 3, 8'hA0, 0, "ep1_retry");
        load(1, 3, 8'hB0);
        do_in(4'd1, P_DATA1, 3, 8'hB0, 3, "ep1_data1_clr");
        load(1, 2, 8'hC0);
        do_in(4'd1, P_DATA0, 2, 8'hC0, 0, "ep1_after_clr");

        do_in(4'd2, P_NAK, 0, 8'h00, 0, "ep2_nak");
        load(2, 2, 8'hD0);
        epHalted_i = 4'b0100;
        do_in(4'd2, P_STALL, 0, 8'h00, 0, "ep2_stall");
        epHalted_i = 4'b0000;
        do_in(4'd2, P_DATA0, 2, 8'hD0, 0, "ep2_after_stall");

        load(3, 70, 8'h00);
        do_in(4'd3, P_DATA0, 64, 8'h00, 0, "ep3_full");
        do_in(4'd3, P_DATA1, 6, 8'h40, 0, "ep3_rest");

        load(0, 64, 8'h80);
        do_in(4'd0, P_DATA0, 64, 8'h80, 0, "ep0_max");
`ifdef USB_IN_ZLP_EN
        do_in(4'd0, P_DATA1, 0, 8'h00, 0, "ep0_zlp");
`else
        do_in(4'd0, P_NAK, 0, 8'h00, 0, "ep0_nak");
`endif

        s = n_start;
        inTokenValid_i = 1'b1;
        inTokenEp_i    = 4'd7;
        tick();
        inTokenValid_i = 1'b0;
        repeat (10) tick();
        check("ep7_no_start", n_start - s, 0);
        check("ep7_idle", busy_o, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
